// File: rtl/sim_trig_gen.sv
// Simulation read-trigger generator: issues read strobes/addresses in continuous, burst or periodic runs.
// Optional per-run read counter output (out_ntrig) is enabled by defining SIM_TRIG_CNT_EN.
module sim_trig_gen #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena_trig,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] burst_len,
  input  logic [CNT_W-1:0]  period,
  output logic              out_rena,
  output logic [ADDR_W-1:0] out_raddr,
  output logic              out_busy,
  output logic              out_done
`ifdef SIM_TRIG_CNT_EN
  ,
  output logic [CNT_W-1:0]  out_ntrig
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_BURST    = 2'd1;
  localparam logic [1:0] MODE_PERIODIC = 2'd2;

  state_t              state_r, state_n;
  logic                prev_ena_r;
  logic [1:0]          mode_r, mode_n;
  logic [CNT_W-1:0]    period_r, period_n;
  logic [CNT_W-1:0]    gap_r, gap_n;
  logic [ADDR_W-1:0]   rem_r, rem_n;
  logic                rena_r, rena_n;
  logic [ADDR_W-1:0]   raddr_r, raddr_n;
  logic                busy_r, busy_n;
  logic                done_r, done_n;
  logic                start_s;
  logic                issue_s;
  logic                clr_s;
`ifdef SIM_TRIG_CNT_EN
  logic [CNT_W-1:0]    ntrig_r, ntrig_n;
`endif

  assign start_s = ena_trig & ~prev_ena_r;

  // State, latched run configuration and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      prev_ena_r <= 1'b0;
      mode_r     <= 2'd0;
      period_r   <= '0;
      gap_r      <= '0;
      rem_r      <= '0;
      rena_r     <= 1'b0;
      raddr_r    <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef SIM_TRIG_CNT_EN
      ntrig_r    <= '0;
`endif
    end else begin
      state_r    <= state_n;
      prev_ena_r <= ena_trig;
      mode_r     <= mode_n;
      period_r   <= period_n;
      gap_r      <= gap_n;
      rem_r      <= rem_n;
      rena_r     <= rena_n;
      raddr_r    <= raddr_n;
      busy_r     <= busy_n;
      done_r     <= done_n;
`ifdef SIM_TRIG_CNT_EN
      ntrig_r    <= ntrig_n;
`endif
    end
  end

  // Next-state and next-output decode; rem_r counts burst reads still owed after the current one
  always_comb begin
    state_n  = state_r;
    mode_n   = mode_r;
    period_n = period_r;
    gap_n    = gap_r;
    rem_n    = rem_r;
    raddr_n  = raddr_r;
    done_n   = 1'b0;
    issue_s  = 1'b0;
    clr_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (start_s) begin
          mode_n   = mode;
          period_n = period;
          clr_s    = 1'b1;
          if ((mode == MODE_BURST) && (burst_len == '0)) begin
            done_n = 1'b1;
          end else begin
            issue_s = 1'b1;
            raddr_n = start_addr;
            rem_n   = burst_len - ADDR_W'(1);
            if ((mode == MODE_PERIODIC) && (period != '0)) begin
              state_n = GAP;
              gap_n   = period;
            end else begin
              state_n = RUN;
            end
          end
        end else begin
          state_n = IDLE;
        end
      end

      RUN: begin
        if (mode_r == MODE_BURST) begin
          if (rem_r == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            issue_s = 1'b1;
            raddr_n = raddr_r + ADDR_W'(1);
            rem_n   = rem_r - ADDR_W'(1);
          end
        end else if (!ena_trig) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          issue_s = 1'b1;
          raddr_n = raddr_r + ADDR_W'(1);
          if ((mode_r == MODE_PERIODIC) && (period_r != '0)) begin
            state_n = GAP;
            gap_n   = period_r;
          end else begin
            state_n = RUN;
          end
        end
      end

      GAP: begin
        if (!ena_trig) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (gap_r <= CNT_W'(1)) begin
          state_n = RUN;
          gap_n   = '0;
        end else begin
          gap_n = gap_r - CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    rena_n = issue_s;
    busy_n = (state_n != IDLE);
  end

`ifdef SIM_TRIG_CNT_EN
  // Saturating per-run read counter, restarted at each run start
  always_comb begin
    ntrig_n = ntrig_r;
    if (clr_s) begin
      ntrig_n = issue_s ? CNT_W'(1) : '0;
    end else if (issue_s && (ntrig_r != '1)) begin
      ntrig_n = ntrig_r + CNT_W'(1);
    end else begin
      ntrig_n = ntrig_r;
    end
  end

  assign out_ntrig = ntrig_r;
`endif

  assign out_rena  = rena_r;
  assign out_raddr = raddr_r;
  assign out_busy  = busy_r;
  assign out_done  = done_r;

endmodule

// File: tb/tb_sim_trig_gen.sv
// Directed self-checking bench for sim_trig_gen (ADDR_W=12, CNT_W=16); honours SIM_TRIG_CNT_EN.
module tb_sim_trig_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena_trig;
  logic [1:0]  mode;
  logic [11:0] start_addr;
  logic [11:0] burst_len;
  logic [15:0] period;
  logic        out_rena;
  logic [11:0] out_raddr;
  logic        out_busy;
  logic        out_done;
`ifdef SIM_TRIG_CNT_EN
  logic [15:0] out_ntrig;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  sim_trig_gen #(.ADDR_W(12), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena_trig   (ena_trig),
    .mode       (mode),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .period     (period),
    .out_rena   (out_rena),
    .out_raddr  (out_raddr),
    .out_busy   (out_busy),
    .out_done   (out_done)
`ifdef SIM_TRIG_CNT_EN
    ,
    .out_ntrig  (out_ntrig)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rena, input logic [11:0] addr,
                         input logic busy, input logic done);
    chk({tag, ".rena"}, {31'd0, out_rena}, {31'd0, rena});
    chk({tag, ".raddr"}, {20'd0, out_raddr}, {20'd0, addr});
    chk({tag, ".busy"}, {31'd0, out_busy}, {31'd0, busy});
    chk({tag, ".done"}, {31'd0, out_done}, {31'd0, done});
  endtask

  initial begin
    logic [8:0] per_pat;
    logic [11:0] wrap_addr [4];
    per_pat = 9'b100100100;
    wrap_addr[0] = 12'hFFE; wrap_addr[1] = 12'hFFF; wrap_addr[2] = 12'h000; wrap_addr[3] = 12'h001;

    rst = 1'b1; ena_trig = 1'b0; mode = 2'd0;
    start_addr = 12'h000; burst_len = 12'h000; period = 16'd0;
    tick();
    tick();
    chk_out("reset", 1'b0, 12'h000, 1'b0, 1'b0);

    // continuous, 5 cycles from 0x010
    rst = 1'b0; mode = 2'd0; start_addr = 12'h010; ena_trig = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("cont%0d", i), 1'b1, 12'h010 + 12'(i), 1'b1, 1'b0);
    end
    ena_trig = 1'b0;
    tick();
    chk_out("cont_end", 1'b0, 12'h014, 1'b0, 1'b1);
`ifdef SIM_TRIG_CNT_EN
    chk("cont_ntrig", {16'd0, out_ntrig}, 32'd5);
`endif
    tick();
    chk_out("cont_idle", 1'b0, 12'h014, 1'b0, 1'b0);

    // burst of 4 from 0x0FE, ena pulsed one cycle, mode changed mid-run
    mode = 2'd1; start_addr = 12'h0FE; burst_len = 12'd4; ena_trig = 1'b1;
    tick();
    chk_out("burst0", 1'b1, 12'h0FE, 1'b1, 1'b0);
    ena_trig = 1'b0; mode = 2'd0; burst_len = 12'd1; start_addr = 12'h777;
    tick();
    chk_out("burst1", 1'b1, 12'h0FF, 1'b1, 1'b0);
    tick();
    chk_out("burst2", 1'b1, 12'h100, 1'b1, 1'b0);
    tick();
    chk_out("burst3", 1'b1, 12'h101, 1'b1, 1'b0);
    tick();
    chk_out("burst_end", 1'b0, 12'h101, 1'b0, 1'b1);
    tick();
    chk_out("burst_idle", 1'b0, 12'h101, 1'b0, 1'b0);

    // continuous address wrap
    mode = 2'd0; start_addr = 12'hFFE; ena_trig = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("wrap%0d", i), 1'b1, wrap_addr[i], 1'b1, 1'b0);
    end
    ena_trig = 1'b0;
    tick();
    chk_out("wrap_end", 1'b0, 12'h001, 1'b0, 1'b1);

    // periodic, period=2, 9 cycles
    mode = 2'd2; period = 16'd2; start_addr = 12'h020; ena_trig = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_out($sformatf("per%0d", i), per_pat[8-i], 12'h020 + 12'(i / 3), 1'b1, 1'b0);
    end
    ena_trig = 1'b0;
    tick();
    chk_out("per_end", 1'b0, 12'h022, 1'b0, 1'b1);

    // periodic run ended from GAP
    period = 16'd3; start_addr = 12'h030; ena_trig = 1'b1;
    tick();
    chk_out("pgap0", 1'b1, 12'h030, 1'b1, 1'b0);
    tick();
    chk_out("pgap1", 1'b0, 12'h030, 1'b1, 1'b0);
    ena_trig = 1'b0;
    tick();
    chk_out("pgap_end", 1'b0, 12'h030, 1'b0, 1'b1);

    // burst with ena held high afterwards: no restart
    mode = 2'd1; burst_len = 12'd2; start_addr = 12'h300; ena_trig = 1'b1;
    tick();
    chk_out("hold0", 1'b1, 12'h300, 1'b1, 1'b0);
    tick();
    chk_out("hold1", 1'b1, 12'h301, 1'b1, 1'b0);
    tick();
    chk_out("hold_end", 1'b0, 12'h301, 1'b0, 1'b1);
    tick();
    chk_out("hold_norestart", 1'b0, 12'h301, 1'b0, 1'b0);
    ena_trig = 1'b0;
    tick();

    // burst_len = 0: done only
    burst_len = 12'd0; start_addr = 12'h555; ena_trig = 1'b1;
    tick();
    chk_out("blen0", 1'b0, 12'h301, 1'b0, 1'b1);
`ifdef SIM_TRIG_CNT_EN
    chk("blen0_ntrig", {16'd0, out_ntrig}, 32'd0);
`endif
    tick();
    chk_out("blen0_idle", 1'b0, 12'h301, 1'b0, 1'b0);
    ena_trig = 1'b0;
    tick();

    // reset at third read of an 8-read burst
    burst_len = 12'd8; start_addr = 12'h400; ena_trig = 1'b1;
    tick();
    chk_out("rstb0", 1'b1, 12'h400, 1'b1, 1'b0);
    ena_trig = 1'b0;
    tick();
    tick();
    chk_out("rstb2", 1'b1, 12'h402, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk_out("rstb_abort", 1'b0, 12'h000, 1'b0, 1'b0);
`ifdef SIM_TRIG_CNT_EN
    chk("rstb_ntrig", {16'd0, out_ntrig}, 32'd0);
`endif

    // ena high through reset release starts at the first edge out of reset
    mode = 2'd0; start_addr = 12'h050; ena_trig = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk_out("rel0", 1'b1, 12'h050, 1'b1, 1'b0);
    ena_trig = 1'b0;
    tick();
    chk_out("rel_end", 1'b0, 12'h050, 1'b0, 1'b1);
    tick();
    chk_out("rel_idle", 1'b0, 12'h050, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_trig_gen.md
SIM_TRIG_GEN -- requirements
Module: sim_trig_gen

Interface
REQ-001 Parameter ADDR_W, default 12, read-address width.
REQ-002 Parameter CNT_W, default 16, width of period and count fields.
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ena_trig  input  1  trigger enable, level; a 0->1 transition starts a run.
REQ-006 mode  input  2  0=continuous, 1=burst, 2=periodic, 3=reserved (treated as continuous).
REQ-007 start_addr  input  ADDR_W  first read address of a run.
REQ-008 burst_len  input  ADDR_W  number of reads in burst mode.
REQ-009 period  input  CNT_W  idle cycles between reads in periodic mode.
REQ-010 out_rena  output  1  read enable, registered.
REQ-011 out_raddr  output  ADDR_W  read address, registered.
REQ-012 out_busy  output  1  high while a run is active.
REQ-013 out_done  output  1  one-cycle pulse at run end.

Function
REQ-014 Registered prev_ena holds ena_trig from the previous edge; start = ena_trig & ~prev_ena, evaluated only in IDLE.
REQ-015 States: IDLE, RUN, GAP; IDLE->RUN on start; reset forces IDLE.
REQ-016 Latency 0 registered: at the edge where start is sampled, out_rena=1, out_raddr=start_addr, out_busy=1.
REQ-017 mode, start_addr, burst_len, period latched at start; input changes mid-run ignored.
REQ-018 Continuous: one read per cycle, address +1 per read; run ends at the first edge ena_trig samples 0 (out_rena=0 that edge, out_done=1, ->IDLE).
REQ-019 Burst: exactly burst_len reads on consecutive cycles from start_addr; ena_trig ignored until run ends; out_done pulses the edge after the last read; new run needs a fresh 0->1 edge of ena_trig.
REQ-020 Burst with burst_len=0: no read issued, out_rena=0, out_done=1 at the start edge, stays IDLE.
REQ-021 Periodic: read, then GAP for period cycles with out_rena=0, repeat; period=0 gives one read per cycle; ends as REQ-018, including from GAP.
REQ-022 Address arithmetic modulo 2^ADDR_W; all-ones wraps to 0 with no flag.
REQ-023 out_raddr holds last issued address when out_rena=0.
REQ-024 out_busy=0 in IDLE and on the out_done edge.
REQ-025 ena_trig held high after a continuous/periodic run cannot end; held high after burst end does not restart.

Reset
REQ-026 rst sampled high: state=IDLE, out_rena=0, out_raddr=0, out_busy=0, out_done=0, prev_ena=0, internal counters=0.
REQ-027 rst mid-run aborts without out_done pulse.
REQ-028 ena_trig high through reset release starts a run at the first edge with rst=0.

Configuration
REQ-029 Macro SIM_TRIG_CNT_EN defined: extra output out_ntrig [CNT_W-1:0], count of reads issued in current run, cleared at start and by rst, saturating at all-ones, held after run end.
REQ-030 Macro undefined: out_ntrig port and counter absent; all other behaviour identical.

Verification
REQ-031 Continuous: mode=0, start_addr=0x010, ena_trig high 5 cycles -> out_rena high 5 cycles, addresses 0x010..0x014, out_done one cycle after ena_trig low.
REQ-032 Burst: mode=1, start_addr=0x0FE, burst_len=4, ena_trig pulsed 1 cycle -> addresses 0x0FE,0x0FF,0x100,0x101, out_done on 5th edge, out_busy high 4 cycles.
REQ-033 Wrap: mode=0, start_addr=0xFFE, 4 cycles -> 0xFFE,0xFFF,0x000,0x001.
REQ-034 Periodic: mode=2, period=2, ena_trig high 9 cycles -> out_rena pattern 1,0,0,1,0,0,1,0,0, addresses +1 per read.
REQ-035 Reset mid-burst: burst_len=8, rst at 3rd read -> next edge all outputs 0, no out_done; with SIM_TRIG_CNT_EN out_ntrig=0.
REQ-036 Burst_len=0 and mode change mid-run: out_done only, no rena; mode switched 1->0 mid-burst does not alter the 4-read sequence.
